// File: rtl/fetch_queue_if.sv
// Fetch/decode handshake bundle for the instruction prefetch queue.
// master = fetch+decode side, slave = queue side.
interface fetch_queue_if #(
    parameter int DEPTH = 4
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic          f_valid;
    logic [31:0]   f_PC;
    logic [31:0]   f_instr;
    logic          full;
    logic          d_ready;
    logic          d_valid;
    logic [31:0]   d_PC;
    logic [31:0]   d_instr;
    logic          flush;
    logic [CW-1:0] count;

    modport master (
        output f_valid, f_PC, f_instr, d_ready, flush,
        input  full, d_valid, d_PC, d_instr, count
    );

    modport slave (
        input  f_valid, f_PC, f_instr, d_ready, flush,
        output full, d_valid, d_PC, d_instr, count
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular prefetch FIFO between fetch and decode.
// Redirect flush keeps the oldest survivor as the delay slot.
module fetch_queue #(
    parameter int DEPTH      = 4,
    parameter bit DELAY_SLOT = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    fetch_queue_if.slave  q
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic [CW-1:0] cnt;

    logic          pop;
    logic          push;
    logic [AW-1:0] rd_nx;
    logic [CW-1:0] left;

    assign q.d_valid = (cnt != '0);
    assign q.full    = (cnt == CW'(DEPTH));
    assign q.count   = cnt;
    assign q.d_PC    = mem[rd_ptr][63:32];
    assign q.d_instr = mem[rd_ptr][31:0];

    assign pop   = q.d_valid & q.d_ready;
    assign push  = q.f_valid & ~q.full;
    assign rd_nx = rd_ptr + AW'(pop);
    assign left  = cnt - CW'(pop);

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            cnt    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (q.flush) begin
            unique case (1'b1)
                // oldest stored survivor becomes the delay slot
                (DELAY_SLOT && left != '0): begin
                    rd_ptr <= rd_nx;
                    wr_ptr <= rd_nx + AW'(1);
                    cnt    <= CW'(1);
                end
                (DELAY_SLOT && left == '0 && push): begin
                    mem[wr_ptr] <= {q.f_PC, q.f_instr};
                    rd_ptr      <= wr_ptr;
                    wr_ptr      <= wr_ptr + AW'(1);
                    cnt         <= CW'(1);
                end
                default: begin
                    rd_ptr <= wr_ptr;
                    cnt    <= '0;
                end
            endcase
        end else begin
            if (push) begin
                mem[wr_ptr] <= {q.f_PC, q.f_instr};
                wr_ptr      <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_nx;
            cnt    <= cnt + CW'(push) - CW'(pop);
        end
    end
endmodule
